// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
//   Bundles the issue, decode-hazard, writeback-request and register-file
//   write-port signals of rf_wb_arbiter.
//
//   slave  : the arbiter side. It takes the valids, register addresses and
//            data as inputs, and drives the readies, hazards and Rw/busW/RegWr.
//   master : the IDU/EXU/LSU side, which is the reverse of slave.
//
//   Handshake semantics for every valid/ready pair:
//     - A transfer happens on a rising clock edge where valid and ready are
//       both 1.
//     - A requester holds valid and its payload stable until that edge.
//     - ready is a combinational function of the current inputs and state.
//       It is never withdrawn within a cycle.
interface rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;

    logic [ADDR_WIDTH-1:0] Ra;
    logic [ADDR_WIDTH-1:0] Rb;
    logic                  hazard_a;
    logic                  hazard_b;

    logic                  exu_valid;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  exu_ready;

    logic                  lsu_valid;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  lsu_ready;

    logic [ADDR_WIDTH-1:0] Rw;
    logic [DATA_WIDTH-1:0] busW;
    logic                  RegWr;

    modport slave (
        input  issue_valid, issue_rd, Ra, Rb,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, hazard_a, hazard_b,
        output exu_ready, lsu_ready,
        output Rw, busW, RegWr
    );

    modport master (
        output issue_valid, issue_rd, Ra, Rb,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, hazard_a, hazard_b,
        input  exu_ready, lsu_ready,
        input  Rw, busW, RegWr
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Controls the write port of the register file and keeps its scoreboard.
//   - EXU and LSU share the single write port. A round-robin arbiter picks
//     one of them each cycle.
//   - A busy bit per register records each destination that IDU has
//     reserved and that no writeback has yet completed.
//   - Read-after-write hazards on Ra/Rb are reported to decode.
//
// Ports:
//   Wrclk  : clock; all state updates on the rising edge.
//   rst_n  : asynchronous, active-low reset.
//   bus    : rf_wb_arbiter_if.slave, containing
//     - issue_valid/issue_rd/issue_ready : destination reservations from IDU
//     - Ra/Rb -> hazard_a/hazard_b       : decode hazard query
//     - exu_*/lsu_*                      : writeback requests
//     - Rw/busW/RegWr                    : registered register-file write port
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic             Wrclk,
    input  logic             rst_n,
    rf_wb_arbiter_if.slave   bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    // 1 when the LSU received the most recent grant, so the EXU wins the
    // next contention.
    logic                  last_grant_lsu;

    logic                  exu_grant;
    logic                  lsu_grant;
    logic                  wb_fire;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  issue_ok;
    logic                  issue_fire;

    logic [ADDR_WIDTH-1:0] rw_q;
    logic [DATA_WIDTH-1:0] busw_q;
    logic                  regwr_q;

    // Round-robin grant. It depends only on the valids and the last winner,
    // so a ready never changes while its valid is held.
    always_comb begin
        exu_grant = rst_n & bus.exu_valid & (~bus.lsu_valid | last_grant_lsu);
        lsu_grant = rst_n & bus.lsu_valid & (~bus.exu_valid | ~last_grant_lsu);
    end

    assign wb_fire = exu_grant | lsu_grant;
    assign wb_rd   = exu_grant ? bus.exu_rd   : bus.lsu_rd;
    assign wb_data = exu_grant ? bus.exu_data : bus.lsu_data;

    // A reservation waits while its destination still has an earlier write
    // outstanding. x0 is never tracked, so a reservation of x0 is always
    // accepted.
    assign issue_ok   = rst_n & ((bus.issue_rd == '0) | ~busy[bus.issue_rd]);
    assign issue_fire = bus.issue_valid & issue_ok;

    // A writeback clears its bit first and a reservation sets its bit after.
    // If both hit the same register in one cycle, that register was not busy
    // (issue_ok), and the new reservation must survive.
    always_comb begin
        busy_next = busy;
        if (wb_fire) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (issue_fire && (bus.issue_rd != '0)) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge Wrclk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= '0;
            last_grant_lsu <= 1'b1;
        end else begin
            busy <= busy_next;
            if (wb_fire) begin
                last_grant_lsu <= lsu_grant;
            end
        end
    end

    // Write port. Rw and busW capture every granted request, including a
    // request to x0. RegWr stays low for x0 so that x0 is never written.
    always_ff @(posedge Wrclk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= '0;
            busw_q  <= '0;
            regwr_q <= 1'b0;
        end else begin
            if (wb_fire) begin
                rw_q    <= wb_rd;
                busw_q  <= wb_data;
                regwr_q <= (wb_rd != '0);
            end else begin
                regwr_q <= 1'b0;
            end
        end
    end

    // The in-flight term covers the cycle after busy has cleared, while the
    // register file has not yet taken the write.
    always_comb begin
        bus.hazard_a = rst_n & (bus.Ra != '0) &
                       (busy[bus.Ra] | (regwr_q & (rw_q == bus.Ra)));
        bus.hazard_b = rst_n & (bus.Rb != '0) &
                       (busy[bus.Rb] | (regwr_q & (rw_q == bus.Rb)));
    end

    assign bus.exu_ready   = exu_grant;
    assign bus.lsu_ready   = lsu_grant;
    assign bus.issue_ready = issue_ok;
    assign bus.Rw          = rw_q;
    assign bus.busW        = busw_q;
    assign bus.RegWr       = regwr_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
//   Drives the arbiter with directed scenarios and then with random traffic.
//   A reference model predicts the following:
//   - grants, issue_ready and hazards, checked in the same cycle;
//   - the write-port contents after each edge, pushed into exp_q.
//   A separate monitor pops exp_q after every rising edge and compares the
//   entry with Rw/busW/RegWr.
module tb_rf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int EW = 1 + AW + DW;

    logic Wrclk;
    logic rst_n;

    rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Wrclk (Wrclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit            m_busy [32];
    bit            m_regwr;
    logic [AW-1:0] m_rw;
    logic [DW-1:0] m_busw;
    bit            exu_turn;   // EXU wins the next contention
    bit            g_exu;      // grants predicted for the last cycle
    bit            g_lsu;

    logic [EW-1:0] exp_q [$];

    // clock / reset
    initial begin
        Wrclk = 1'b0;
        forever #5 Wrclk = ~Wrclk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_regwr  = 1'b0;
        m_rw     = '0;
        m_busw   = '0;
        exu_turn = 1'b1;
        g_exu    = 1'b0;
        g_lsu    = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.Ra          = '0;
        bus.Rb          = '0;
        bus.exu_valid   = 1'b0;
        bus.exu_rd      = '0;
        bus.exu_data    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = '0;
        bus.lsu_data    = '0;
    endtask

    // Called just after a falling edge, once the inputs for this cycle are set.
    // It checks the combinational outputs, advances the model across the next
    // rising edge, and returns at the following falling edge.
    task automatic step();
        bit            ge, gl, ir, ha, hb;
        logic [AW-1:0] rd;
        #1;
        ge = bus.exu_valid && (!bus.lsu_valid || exu_turn);
        gl = bus.lsu_valid && !ge;
        ir = (bus.issue_rd == 0) || !m_busy[bus.issue_rd];
        ha = (bus.Ra != 0) && (m_busy[bus.Ra] || (m_regwr && m_rw == bus.Ra));
        hb = (bus.Rb != 0) && (m_busy[bus.Rb] || (m_regwr && m_rw == bus.Rb));
        chk("exu_ready",   {63'd0, bus.exu_ready},   {63'd0, ge});
        chk("lsu_ready",   {63'd0, bus.lsu_ready},   {63'd0, gl});
        chk("issue_ready", {63'd0, bus.issue_ready}, {63'd0, ir});
        chk("hazard_a",    {63'd0, bus.hazard_a},    {63'd0, ha});
        chk("hazard_b",    {63'd0, bus.hazard_b},    {63'd0, hb});
        if (ge || gl) begin
            rd = ge ? bus.exu_rd : bus.lsu_rd;
            m_busy[rd] = 1'b0;
            m_rw       = rd;
            m_busw     = ge ? bus.exu_data : bus.lsu_data;
            m_regwr    = (rd != 0);
            exu_turn   = gl;
        end else begin
            m_regwr = 1'b0;
        end
        if (bus.issue_valid && ir && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        exp_q.push_back({m_regwr, m_rw, m_busw});
        g_exu = ge;
        g_lsu = gl;
        @(negedge Wrclk);
    endtask

    // scoreboard monitor
    always @(posedge Wrclk) begin
        logic [EW-1:0] e;
        #2;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write_port", {{(64-EW){1'b0}}, bus.RegWr, bus.Rw, bus.busW}, {{(64-EW){1'b0}}, e});
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge Wrclk);
        chk("reset_regwr", {63'd0, bus.RegWr}, 64'd0);
        chk("reset_rw",    {59'd0, bus.Rw},    64'd0);
        chk("reset_busw",  {32'd0, bus.busW},  64'd0);
        chk("reset_issue_ready", {63'd0, bus.issue_ready}, 64'd0);
        rst_n = 1'b1;

        // Contention right after reset: the grants go EXU, LSU, EXU, LSU.
        bus.exu_valid = 1; bus.exu_rd = 1; bus.exu_data = 32'h11;
        bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("contention_rw", {59'd0, bus.Rw}, (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        clear_inputs();
        step();

        // Single EXU write.
        bus.exu_valid = 1; bus.exu_rd = 5; bus.exu_data = 32'hDEADBEEF;
        step();
        bus.exu_valid = 0;
        chk("single_regwr", {63'd0, bus.RegWr}, 64'd1);
        chk("single_rw",    {59'd0, bus.Rw},    64'd5);
        chk("single_busw",  {32'd0, bus.busW},  64'hDEADBEEF);
        step();
        chk("single_regwr_drop", {63'd0, bus.RegWr}, 64'd0);

        // RAW through the scoreboard and then through the in-flight term.
        bus.issue_valid = 1; bus.issue_rd = 7; bus.Ra = 7;
        step();
        bus.issue_valid = 0;
        chk("raw_busy", {63'd0, bus.hazard_a}, 64'd1);
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h77;
        step();
        bus.lsu_valid = 0;
        chk("raw_inflight", {63'd0, bus.hazard_a}, 64'd1);
        step();
        chk("raw_clear", {63'd0, bus.hazard_a}, 64'd0);

        // WAW stall on x3.
        bus.issue_valid = 1; bus.issue_rd = 3;
        step();
        step();
        step();
        bus.exu_valid = 1; bus.exu_rd = 3; bus.exu_data = 32'h33;
        step();
        bus.exu_valid = 0;
        chk("waw_release", {63'd0, bus.issue_ready}, 64'd1);
        step();
        bus.issue_valid = 0;

        // x0 is never reserved and never written.
        bus.issue_valid = 1; bus.issue_rd = 0; bus.Ra = 0;
        step();
        bus.issue_valid = 0;
        bus.exu_valid = 1; bus.exu_rd = 0; bus.exu_data = 32'hFFFFFFFF;
        step();
        bus.exu_valid = 0;
        chk("x0_regwr",  {63'd0, bus.RegWr},    64'd0);
        chk("x0_hazard", {63'd0, bus.hazard_a}, 64'd0);
        step();

        // Asynchronous reset mid-stream while a write is on the port.
        bus.exu_valid = 1; bus.exu_rd = 9; bus.exu_data = 32'h99; bus.Ra = 9; bus.Rb = 9;
        step();
        chk("pre_reset_regwr", {63'd0, bus.RegWr}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_regwr",     {63'd0, bus.RegWr},     64'd0);
        chk("areset_rw",        {59'd0, bus.Rw},        64'd0);
        chk("areset_busw",      {32'd0, bus.busW},      64'd0);
        chk("areset_hazard_a",  {63'd0, bus.hazard_a},  64'd0);
        chk("areset_hazard_b",  {63'd0, bus.hazard_b},  64'd0);
        chk("areset_exu_ready", {63'd0, bus.exu_ready}, 64'd0);
        exp_q.delete();
        model_reset();
        @(negedge Wrclk);
        rst_n = 1'b1;
        bus.exu_valid = 1; bus.exu_rd = 4; bus.exu_data = 32'h44;
        bus.lsu_valid = 1; bus.lsu_rd = 6; bus.lsu_data = 32'h66;
        step();
        chk("post_reset_exu_first", {59'd0, bus.Rw}, 64'd4);
        clear_inputs();
        step();

        // Random traffic. A requester keeps its request until it is granted.
        for (int n = 0; n < 600; n++) begin
            if (!bus.exu_valid || g_exu) begin
                bus.exu_valid = ($urandom_range(0, 2) != 0);
                bus.exu_rd    = AW'($urandom_range(0, 7));
                bus.exu_data  = $urandom;
            end
            if (!bus.lsu_valid || g_lsu) begin
                bus.lsu_valid = ($urandom_range(0, 2) != 0);
                bus.lsu_rd    = AW'($urandom_range(0, 7));
                bus.lsu_data  = $urandom;
            end
            bus.issue_valid = ($urandom_range(0, 1) != 0);
            bus.issue_rd    = AW'($urandom_range(0, 7));
            bus.Ra          = AW'($urandom_range(0, 7));
            bus.Rb          = ($urandom_range(0, 3) == 0) ? bus.Ra : AW'($urandom_range(0, 7));
            step();
        end
        clear_inputs();
        step();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Wrclk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
